rgb_to_yuv_encoder: RTL
=======================

Name: rgb_to_yuv_encoder

Overview:
- Compression-side counterpart of the milestone-1 decompressor. Reads interleaved RGB pixels from the SRAM RGB region and converts each pixel to YUV (BT.601 fixed-point).
- Downsamples U/V 2:1 horizontally and writes packed Y, U and V planes back to SRAM.
- Produces exactly the memory image the decompressor consumes. Sits on the shared SRAM port, started by a top-level FSM.

Parameters:
- RGB_BASE, 146944, first RGB word address.
- Y_BASE, 0, first Y word address.
- U_BASE, 38400, first U word address.
- V_BASE, 57600, first V word address.
- NUM_GROUPS, 19200, number of 4-pixel groups (320x240 / 4).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Enable  in  1  start; sampled only in S_IDLE.
- SRAM_address  out  18  SRAM word address.
- SRAM_read_data  in  16  SRAM read data, valid 2 cycles after address presented.
- SRAM_write_data  out  16  SRAM write data.
- SRAM_we_n  out  1  active-low write enable.
- Done  out  1  one-cycle pulse after the final write.

Behaviour:
- Reset (synchronous, Reset=1 at a rising edge, any state):
  - state=S_IDLE, SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1, Done=0.
  - Group counter g=0, all capture and result registers 0.
  - Reset mid-run abandons the group; no further writes.
- RGB layout: per pixel pair, three words {R0,G0}, {B0,R1}, {G1,B1}. Group g = pixels 4g..4g+3 = words RGB_BASE+6g .. +6g+5.
- Output per group:
  - Y_BASE+2g = {Y0,Y1}.
  - Y_BASE+2g+1 = {Y2,Y3}.
  - U_BASE+g = {Ua,Ub}.
  - V_BASE+g = {Va,Vb}.
  - Even pixel goes in [15:8] throughout.
- FSM (registered outputs), 16 cycles per group:
  - S_IDLE: we_n=1. Enable=1 -> S_READ, r=0, address=RGB_BASE+6g.
  - S_READ (6 cycles, r=0..5): address=RGB_BASE+6g+r. Word r-2 captured when r>=2. After r=5 -> S_DRAIN.
  - S_DRAIN (2 cycles): capture words 4 and 5 -> S_CONV.
  - S_CONV (4 cycles, p=0..3): one pixel per cycle through the converter; register Yp, Up, Vp -> S_WRITE.
  - S_WRITE (4 cycles, w=0..3): we_n=0 with address/data per the output layout above, in order Y-word0, Y-word1, U, V. After w=3: if g=NUM_GROUPS-1 -> S_DONE, else g+1 and -> S_READ.
  - S_DONE (1 cycle): Done=1, we_n=1, g=0 -> S_IDLE.
- SRAM_we_n is 1 in every state except S_WRITE. No read is issued during S_WRITE.
- Enable is ignored outside S_IDLE. Enable held high after Done restarts the frame from g=0.
- Conversion arithmetic: R, G, B are 8-bit unsigned, zero-extended; products signed 32-bit.
  - Y = ((66R+129G+25B+128)>>>8)+16
  - U = ((-38R-74G+112B+128)>>>8)+128
  - V = ((112R-94G-18B+128)>>>8)+128
  - Each result clipped to [0,255]: negative -> 0, >255 -> 255.
- Downsampling:
  - Ua = (U0+U1+1)>>1, Ub = (U2+U3+1)>>1, using 9-bit intermediate sums.
  - Va, Vb computed the same way from V0..V3.
- Latency: Enable-sampling edge to Done high = 16*NUM_GROUPS+1 cycles.
- Address arithmetic is 18-bit. The last group touches RGB_BASE+115199 = 262143 (max address, no wrap).

Decomposition:
- Shared package (define_state.h family):
  - Encoder state enum type: S_IDLE, S_READ, S_DRAIN, S_CONV, S_WRITE, S_DONE.
  - Conversion coefficient constants (66, 129, 25, -38, -74, 112, -94, -18).
  - Base-address constants, shared with the decompressor.
- Sub-module rgb2yuv_pixel: combinational, 24-bit RGB in, 24-bit clipped YUV out. Instantiated once.

Test Plan:
- NUM_GROUPS=1, all RGB words 0x0000 -> writes 0x1010 at Y0 and Y1, 0x8080 at U_BASE and V_BASE; Done exactly 17 cycles after Enable edge.
- NUM_GROUPS=1, all words 0xFFFF -> Y words 0xEBEB, U 0x8080, V 0x8080.
- Pixels red, blue, red, blue (words 0xFF00, 0x0000, 0x00FF, repeated) -> Y words 0x5229, 0x5229; U 0xA5A5; V 0xAFAF.
- NUM_GROUPS=2: second group reads addresses 146950..146955 and writes Y 2 and 3, U_BASE+1, V_BASE+1; we_n low on exactly 8 cycles total.
- Reset=1 asserted in S_CONV of group 0 -> next cycle state S_IDLE, we_n=1, address 0, no writes seen; a fresh Enable restarts at RGB_BASE.
- Enable pulsed during S_READ/S_WRITE -> no effect on sequence. Full frame (default parameters) completes with last write at V_BASE+19199 and Done after 307201 cycles.

Source files
------------

// File: rtl/rgb_to_yuv_encoder_pkg.sv
// Shared definitions for the RGB-to-YUV encoder.
// Holds the encoder state type, BT.601 fixed-point coefficients, the SRAM base
// addresses shared with the decompressor, and small arithmetic helpers.
package rgb_to_yuv_encoder_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_CONV,
    S_WRITE,
    S_DONE
  } enc_state_t;

  // BT.601 coefficients, scaled by 256
  localparam int signed COEF_Y_R = 66;
  localparam int signed COEF_Y_G = 129;
  localparam int signed COEF_Y_B = 25;
  localparam int signed COEF_U_R = -38;
  localparam int signed COEF_U_G = -74;
  localparam int signed COEF_U_B = 112;
  localparam int signed COEF_V_R = 112;
  localparam int signed COEF_V_G = -94;
  localparam int signed COEF_V_B = -18;

  // SRAM memory map, shared with the decompressor
  localparam logic [17:0] RGB_BASE_ADDR = 18'd146944;
  localparam logic [17:0] Y_BASE_ADDR   = 18'd0;
  localparam logic [17:0] U_BASE_ADDR   = 18'd38400;
  localparam logic [17:0] V_BASE_ADDR   = 18'd57600;
  localparam int unsigned FRAME_GROUPS  = 19200;

  // Saturate a signed result into an unsigned byte
  function automatic logic [7:0] clip_u8(input logic signed [31:0] x);
    if (x < 32'sd0) begin
      return 8'd0;
    end else if (x > 32'sd255) begin
      return 8'd255;
    end else begin
      return x[7:0];
    end
  endfunction

  // Rounded average of two bytes; 9-bit sum cannot overflow
  function automatic logic [7:0] avg2(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return 8'(s >> 1);
  endfunction

endpackage

// File: rtl/rgb2yuv_pixel.sv
// Combinational single-pixel RGB to YUV converter (BT.601 fixed point).
// Ports:
//   rgb_i  {R, G, B}, 8-bit unsigned each
//   yuv_o  {Y, U, V}, each clipped to [0,255]
module rgb2yuv_pixel
  import rgb_to_yuv_encoder_pkg::*;
(
  input  logic [23:0] rgb_i,
  output logic [23:0] yuv_o
);

  logic signed [31:0] r, g, b;
  logic signed [31:0] y_acc, u_acc, v_acc;

  always_comb begin
    r = {24'd0, rgb_i[23:16]};
    g = {24'd0, rgb_i[15:8]};
    b = {24'd0, rgb_i[7:0]};
    y_acc = ((COEF_Y_R * r + COEF_Y_G * g + COEF_Y_B * b + 32'sd128) >>> 8) + 32'sd16;
    u_acc = ((COEF_U_R * r + COEF_U_G * g + COEF_U_B * b + 32'sd128) >>> 8) + 32'sd128;
    v_acc = ((COEF_V_R * r + COEF_V_G * g + COEF_V_B * b + 32'sd128) >>> 8) + 32'sd128;
    yuv_o = {clip_u8(y_acc), clip_u8(u_acc), clip_u8(v_acc)};
  end

endmodule

// File: rtl/rgb_to_yuv_encoder.sv
// RGB-to-YUV encoder on the shared SRAM port.
// Reads interleaved RGB groups of four pixels, converts them to YUV, halves
// U/V horizontally and writes packed Y, U and V planes back to SRAM.
// Ports:
//   Clock            system clock, rising edge
//   Reset            synchronous active-high reset
//   Enable           start request, sampled only in S_IDLE
//   SRAM_address     word address (registered)
//   SRAM_read_data   read data, valid two cycles after its address
//   SRAM_write_data  write data (registered)
//   SRAM_we_n        active-low write enable (registered)
//   Done             one-cycle pulse after the final write of a frame
module rgb_to_yuv_encoder
  import rgb_to_yuv_encoder_pkg::*;
#(
  parameter logic [17:0] RGB_BASE   = RGB_BASE_ADDR,
  parameter logic [17:0] Y_BASE     = Y_BASE_ADDR,
  parameter logic [17:0] U_BASE     = U_BASE_ADDR,
  parameter logic [17:0] V_BASE     = V_BASE_ADDR,
  parameter int unsigned NUM_GROUPS = FRAME_GROUPS
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Enable,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        Done
);

  enc_state_t       state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic [17:0]      g_q, g_d;
  logic [5:0][15:0] word_q, word_d;
  logic [3:0][7:0]  y_q, y_d, u_q, u_d, v_q, v_d;
  logic [17:0]      address_q, address_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             we_n_q, we_n_d;
  logic             done_q, done_d;

  logic [23:0]      pix_rgb, pix_yuv;
  logic [17:0]      rgb_grp;

  rgb2yuv_pixel u_pixel (
    .rgb_i (pix_rgb),
    .yuv_o (pix_yuv)
  );

  // Pixel p of the captured group; pairs share the middle word {B_even, R_odd}
  always_comb begin
    pix_rgb = '0;
    unique case (step_q[1:0])
      2'd0: pix_rgb = {word_q[0], word_q[1][15:8]};
      2'd1: pix_rgb = {word_q[1][7:0], word_q[2]};
      2'd2: pix_rgb = {word_q[3], word_q[4][15:8]};
      2'd3: pix_rgb = {word_q[4][7:0], word_q[5]};
      default: pix_rgb = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    g_d       = g_q;
    word_d    = word_q;
    y_d       = y_q;
    u_d       = u_q;
    v_d       = v_q;
    address_d = address_q;
    wdata_d   = wdata_q;
    we_n_d    = 1'b1;
    done_d    = 1'b0;
    rgb_grp   = RGB_BASE + g_q * 18'd6;

    unique case (state_q)
      S_IDLE: begin
        if (Enable) begin
          state_d   = S_READ;
          step_d    = 3'd0;
          address_d = rgb_grp;
        end
      end
      S_READ: begin
        // Two-cycle read latency: word r-2 arrives while address r is out
        if (step_q >= 3'd2) begin
          word_d[3'(step_q - 3'd2)] = SRAM_read_data;
        end
        if (step_q == 3'd5) begin
          state_d = S_DRAIN;
          step_d  = 3'd0;
        end else begin
          step_d    = step_q + 3'd1;
          address_d = rgb_grp + 18'(step_q + 3'd1);
        end
      end
      S_DRAIN: begin
        if (step_q[0]) begin
          word_d[5] = SRAM_read_data;
          state_d   = S_CONV;
          step_d    = 3'd0;
        end else begin
          word_d[4] = SRAM_read_data;
          step_d    = 3'd1;
        end
      end
      S_CONV: begin
        y_d[step_q[1:0]] = pix_yuv[23:16];
        u_d[step_q[1:0]] = pix_yuv[15:8];
        v_d[step_q[1:0]] = pix_yuv[7:0];
        if (step_q == 3'd3) begin
          state_d   = S_WRITE;
          step_d    = 3'd0;
          we_n_d    = 1'b0;
          address_d = Y_BASE + g_q * 18'd2;
          wdata_d   = {y_q[0], y_q[1]};
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      S_WRITE: begin
        if (step_q == 3'd3) begin
          if (g_q == 18'(NUM_GROUPS - 1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            g_d       = g_q + 18'd1;
            state_d   = S_READ;
            step_d    = 3'd0;
            address_d = rgb_grp + 18'd6;
          end
        end else begin
          step_d = step_q + 3'd1;
          we_n_d = 1'b0;
          unique case (step_q)
            3'd0: begin
              address_d = Y_BASE + g_q * 18'd2 + 18'd1;
              wdata_d   = {y_q[2], y_q[3]};
            end
            3'd1: begin
              address_d = U_BASE + g_q;
              wdata_d   = {avg2(u_q[0], u_q[1]), avg2(u_q[2], u_q[3])};
            end
            default: begin
              address_d = V_BASE + g_q;
              wdata_d   = {avg2(v_q[0], v_q[1]), avg2(v_q[2], v_q[3])};
            end
          endcase
        end
      end
      S_DONE: begin
        g_d     = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      step_q    <= '0;
      g_q       <= '0;
      word_q    <= '0;
      y_q       <= '0;
      u_q       <= '0;
      v_q       <= '0;
      address_q <= '0;
      wdata_q   <= '0;
      we_n_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      g_q       <= g_d;
      word_q    <= word_d;
      y_q       <= y_d;
      u_q       <= u_d;
      v_q       <= v_d;
      address_q <= address_d;
      wdata_q   <= wdata_d;
      we_n_q    <= we_n_d;
      done_q    <= done_d;
    end
  end

  assign SRAM_address    = address_q;
  assign SRAM_write_data = wdata_q;
  assign SRAM_we_n       = we_n_q;
  assign Done            = done_q;

endmodule
